// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 4:1 mux with a hold limit.
module mux_rr_arbiter #(
  parameter int DW = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [DW-1:0] dout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  state_t state, state_nxt;
  logic [1:0] ptr, ptr_nxt, sel_nxt, k;
  logic [3:0] gnt_nxt, hold_cnt, hold_nxt, others;
  logic found, take;
  function automatic logic [2:0] rr_pick(input logic [3:0] m, input logic [1:0] s);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (m[s + 2'(i)]) r = {1'b1, s + 2'(i)};
    return r;
  endfunction
  // the current owner is never a candidate; in IDLE gnt is zero so all of req competes
  assign others = req & ~gnt;
  assign {found, k} = rr_pick(others, state == IDLE ? ptr : sel + 2'd1);
  assign take = found && (state == IDLE || !req[sel] || hold_cnt == HOLD_LAST);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= |gnt_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end
  always_comb begin
    state_nxt = state == IDLE ? (|req ? GRANT : IDLE)
                              : (!req[sel] && !found ? IDLE : GRANT);
  end
  always_comb begin
    gnt_nxt  = take ? 4'b0001 << k : state_nxt == IDLE ? 4'b0000 : gnt;
    sel_nxt  = take ? k : sel;
    ptr_nxt  = take ? k + 2'd1 : ptr;
    hold_nxt = take || state_nxt == IDLE ? 4'd0
             : hold_cnt == HOLD_LAST ? hold_cnt : hold_cnt + 4'd1;
  end
  assign dout = !busy ? '0 : sel == 2'd0 ? din0 : sel == 2'd1 ? din1 : sel == 2'd2 ? din2 : din3;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed test-plan steps then random traffic against an owner/tenure model.
module tb_mux_rr_arbiter;
  localparam int DW = 8;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [DW-1:0] din [4];
  logic [3:0] gnt;
  logic [1:0] sel;
  logic busy;
  logic [DW-1:0] dout;
  int compared = 0;
  int mismatched = 0;
  int owner = -1;
  int ptr = 0;
  int last_sel = 0;
  int cycles = 0;

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .gnt(gnt), .sel(sel), .busy(busy), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] m, input int s);
    for (int i = 0; i < 4; i++)
      if (m[(s + i) % 4]) return (s + i) % 4;
    return -1;
  endfunction

  task automatic give(input int k);
    owner = k;
    last_sel = k;
    ptr = (k + 1) % 4;
    cycles = 1;
  endtask

  // model: owner holds for `cycles` cycles; contended owners yield once they have had MAX_HOLD
  task automatic model(input logic [3:0] r, input logic rn);
    logic [3:0] oth;
    if (!rn) begin
      owner = -1; ptr = 0; last_sel = 0; cycles = 0;
    end else if (owner < 0) begin
      if (r != 0) give(pick(r, ptr));
    end else begin
      oth = r & ~(4'b0001 << owner);
      if (!r[owner]) begin
        if (oth != 0) give(pick(oth, owner + 1));
        else owner = -1;
      end else if (cycles >= MAX_HOLD && oth != 0) give(pick(oth, owner + 1));
      else cycles++;
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rn);
    logic [3:0] eg;
    logic [DW-1:0] ed;
    for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
    req = r;
    rst_n = rn;
    @(posedge clk);
    model(r, rn);
    #1;
    eg = owner < 0 ? 4'b0000 : 4'b0001 << owner;
    ed = owner < 0 ? '0 : din[owner];
    compared++;
    assert (gnt === eg) else begin
      mismatched++;
      $error("FAIL gnt observed=%b expected=%b", gnt, eg);
    end
    compared++;
    assert (sel === 2'(last_sel)) else begin
      mismatched++;
      $error("FAIL sel observed=%0d expected=%0d", sel, last_sel);
    end
    compared++;
    assert (busy === (owner >= 0)) else begin
      mismatched++;
      $error("FAIL busy observed=%b expected=%b", busy, owner >= 0);
    end
    compared++;
    assert (dout === ed) else begin
      mismatched++;
      $error("FAIL dout observed=%h expected=%h", dout, ed);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    @(negedge clk);
    // reset with all requesting, then release
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    chk4("reset_gnt", gnt, 4'b0000);
    step(4'b1111, 1'b1);
    chk4("post_reset_gnt", gnt, 4'b0001);
    // fairness: 0,1,2,3,0 each for MAX_HOLD cycles
    for (int n = 0; n < 4 * MAX_HOLD + 2; n++) step(4'b1111, 1'b1);
    // single requester from idle
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b1);
    chk4("single_gnt", gnt, 4'b0100);
    step(4'b0000, 1'b1);
    chk4("single_release", gnt, 4'b0000);
    // release handoff
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0010, 1'b1);
    chk4("handoff_gnt", gnt, 4'b0010);
    for (int n = 0; n < 3; n++) step(4'b0011, 1'b1);
    // saturated owner then a competitor
    step(4'b0001, 1'b0);
    for (int n = 0; n < 10; n++) step(4'b0001, 1'b1);
    step(4'b1001, 1'b1);
    chk4("saturated_preempt", gnt, 4'b1000);
    // reset mid-grant
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b1100, 1'b1);
    step(4'b1100, 1'b0);
    chk4("midgrant_reset", gnt, 4'b0000);
    step(4'b1100, 1'b1);
    chk4("midgrant_regrant", gnt, 4'b0100);
    // random traffic, mostly sticky requests with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req ^ (4'b0001 << $urandom_range(0, 3));
      step(r, $urandom_range(0, 39) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
